// File: rtl/conv_pkg.sv
// Shared types and default frame geometry for the convolution pipeline
// (sequencer, convolution engine and gradient stage).
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        GAUSS   = 3'd2,
        DRAIN_G = 3'd3,
        SOBEL   = 3'd4,
        DRAIN_S = 3'd5,
        DONE    = 3'd6
    } phase_t;

    typedef enum logic {
        KERN_GAUSS = 1'b0,
        KERN_SOBEL = 1'b1
    } kern_t;

    localparam int DEFAULT_IMG_W = 16;
    localparam int DEFAULT_IMG_H = 16;

endpackage

// File: rtl/raster_counter.sv
// Two-dimensional raster address counter over [X_MIN..X_MAX] x [Y_MIN..Y_MAX];
// x advances first and wraps into y, and the whole scan wraps back to the origin.
module raster_counter #(
    parameter int X_MIN = 0,
    parameter int X_MAX = 15,
    parameter int Y_MIN = 0,
    parameter int Y_MAX = 15,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         last
);

    localparam logic [W-1:0] XMN = W'(X_MIN);
    localparam logic [W-1:0] XMX = W'(X_MAX);
    localparam logic [W-1:0] YMN = W'(Y_MIN);
    localparam logic [W-1:0] YMX = W'(Y_MAX);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = XMN;
            y_d = YMN;
        end else if (adv) begin
            if (x_q == XMX) begin
                x_d = XMN;
                y_d = (y_q == YMX) ? YMN : y_q + ONE;
            end else begin
                x_d = x_q + ONE;
            end
        end
    end

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= XMN;
            y_q <= YMN;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == XMX) && (y_q == YMX);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller: loads one frame in raster order, then scans interior
// windows through the engine with the Gaussian and/or Sobel kernel.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W   = DEFAULT_IMG_W,
    parameter int IMG_H   = DEFAULT_IMG_H,
    parameter int ADDR_W  = 4,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              gauss_en,
    input  logic              sobel_en,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_x,
    output logic [ADDR_W-1:0] wr_y,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [ADDR_W-1:0] win_x,
    output logic [ADDR_W-1:0] win_y,
    output logic              kern_sel,
    input  logic              res_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        phase
);

    localparam int              OUT_W   = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

    phase_t           state_q, state_d;
    logic             gauss_q, gauss_d;
    logic             sobel_q, sobel_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] out_q, out_d;

    logic start_acc, win_acc, res_ok, in_pass;
    logic load_last, win_last;

    assign start_acc = (state_q == IDLE) && start;
    assign pix_ready = (state_q == LOAD);
    assign wr_en     = pix_valid && pix_ready;
    assign in_pass   = (state_q == GAUSS) || (state_q == SOBEL);
    assign win_valid = in_pass && (out_q < OUT_MAX);
    assign win_acc   = win_valid && win_ready;
    // A result with nothing outstanding is flagged and never decrements.
    assign res_ok    = res_valid && (out_q != '0);

    raster_counter #(
        .X_MIN(0), .X_MAX(IMG_W - 1), .Y_MIN(0), .Y_MAX(IMG_H - 1), .W(ADDR_W)
    ) u_load_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .adv(wr_en),
        .x(wr_x), .y(wr_y), .last(load_last)
    );

    raster_counter #(
        .X_MIN(1), .X_MAX(IMG_W - 2), .Y_MIN(1), .Y_MAX(IMG_H - 2), .W(ADDR_W)
    ) u_win_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .adv(win_acc),
        .x(win_x), .y(win_y), .last(win_last)
    );

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        gauss_d = gauss_q;
        sobel_d = sobel_q;
        err_d   = err_q || (res_valid && (out_q == '0));
        case ({win_acc, res_ok})
            2'b10:   out_d = out_q + OUT_ONE;
            2'b01:   out_d = out_q - OUT_ONE;
            default: out_d = out_q;
        endcase

        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                gauss_d = gauss_en;
                sobel_d = sobel_en;
                err_d   = 1'b0;
                out_d   = '0;
            end
            LOAD: if (wr_en && load_last)
                state_d = gauss_q ? GAUSS : (sobel_q ? SOBEL : DONE);
            GAUSS:   if (win_acc && win_last) state_d = DRAIN_G;
            DRAIN_G: if (out_q == '0) state_d = sobel_q ? SOBEL : DONE;
            SOBEL:   if (win_acc && win_last) state_d = DRAIN_S;
            DRAIN_S: if (out_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gauss_q <= 1'b0;
            sobel_q <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            gauss_q <= gauss_d;
            sobel_q <= sobel_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    assign kern_sel = (state_q == SOBEL || state_q == DRAIN_S) ? KERN_SOBEL : KERN_GAUSS;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized bench for conv_frame_sequencer on a 4x4 frame with two
// outstanding results allowed; expectations come from a frame-level model.
module tb_conv_frame_sequencer;
    import conv_pkg::*;

    localparam int IW     = 4;
    localparam int IH     = 4;
    localparam int AW     = 4;
    localparam int MO     = 2;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, gauss_en, sobel_en, pix_valid, win_ready, res_valid;
    logic          pix_ready, wr_en, win_valid, kern_sel, busy, done, err;
    logic [AW-1:0] wr_x, wr_y, win_x, win_y;
    logic [2:0]    phase;

    int errors = 0;
    int checks = 0;

    localparam logic [25:0] RST_EXP = {1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd1, 4'd1,
                                       1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    logic [25:0] obs_vec;
    assign obs_vec = {pix_ready, wr_en, wr_x, wr_y, win_valid, win_x, win_y,
                      kern_sel, busy, done, err, phase};

    conv_frame_sequencer #(
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .MAX_OUT(MO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .gauss_en(gauss_en),
        .sobel_en(sobel_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .win_valid(win_valid),
        .win_ready(win_ready), .win_x(win_x), .win_y(win_y), .kern_sel(kern_sel),
        .res_valid(res_valid), .busy(busy), .done(done), .err(err), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; gauss_en = 1'b0; sobel_en = 1'b0;
        pix_valid = 1'b1; win_ready = 1'b1; res_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec !== RST_EXP) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs_vec, RST_EXP);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs_vec !== RST_EXP) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs_vec, RST_EXP);
        end
    endtask

    // Runs one frame from IDLE. Entry and exit: 1 time unit after a rising edge, DUT idle.
    task automatic run_frame(input string name, input bit g, input bit s,
                             input int pv_pct, input int wr_pct,
                             input int lat_min, input int lat_max,
                             input int stall_from, input int st_pct, input bit abort);
        int lx[$], ly[$], wx[$], wy[$], wk[$], pend[$];
        int mout, idx, acc_k;
        bit draining, exp_done, nd, finished, aborted, exp_pr, exp_wv;

        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) begin lx.push_back(x); ly.push_back(y); end
        for (int k = 0; k < 2; k++)
            if ((k == 0 && g) || (k == 1 && s))
                for (int y = 1; y <= IH - 2; y++)
                    for (int x = 1; x <= IW - 2; x++) begin
                        wx.push_back(x); wy.push_back(y); wk.push_back(k);
                    end
        mout = 0; draining = 0; exp_done = 0; finished = 0; aborted = 0;

        start = 1'b1; gauss_en = g; sobel_en = s;
        pix_valid = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            pix_valid = ($urandom_range(99) < pv_pct);
            win_ready = (cyc >= stall_from && cyc < stall_from + 5) ? 1'b0
                                                                     : ($urandom_range(99) < wr_pct);
            res_valid = 1'b0;
            idx = -1;
            for (int i = 0; i < pend.size(); i++)
                if (idx < 0 && pend[i] <= cyc) idx = i;
            if (idx >= 0) begin pend.delete(idx); res_valid = 1'b1; end
            start    = (st_pct > 0) && ($urandom_range(99) < st_pct);
            gauss_en = 1'($urandom_range(1));
            sobel_en = 1'($urandom_range(1));

            @(negedge clk);
            exp_pr = (lx.size() != 0);
            exp_wv = !exp_pr && (wx.size() != 0) && !draining && (mout < MO);

            checks++;
            if (pix_ready !== exp_pr) begin
                errors++;
                $display("FAIL %s pix_ready cyc=%0d: got %b expected %b", name, cyc, pix_ready, exp_pr);
            end
            checks++;
            if (wr_en !== (pix_valid && exp_pr)) begin
                errors++;
                $display("FAIL %s wr_en cyc=%0d: got %b expected %b", name, cyc, wr_en, pix_valid && exp_pr);
            end
            if (exp_pr) begin
                checks++;
                if (phase !== 3'(LOAD)) begin
                    errors++;
                    $display("FAIL %s load_phase cyc=%0d: got %0d expected %0d", name, cyc, phase, LOAD);
                end
                if (pix_valid) begin
                    checks++;
                    if ({wr_x, wr_y} !== {AW'(lx[0]), AW'(ly[0])}) begin
                        errors++;
                        $display("FAIL %s wr_addr cyc=%0d: got (%0d,%0d) expected (%0d,%0d)",
                                 name, cyc, wr_x, wr_y, lx[0], ly[0]);
                    end
                end
            end
            checks++;
            if (win_valid !== exp_wv) begin
                errors++;
                $display("FAIL %s win_valid cyc=%0d: got %b expected %b", name, cyc, win_valid, exp_wv);
            end
            if (exp_wv) begin
                checks++;
                if ({win_x, win_y, kern_sel} !== {AW'(wx[0]), AW'(wy[0]), 1'(wk[0])}) begin
                    errors++;
                    $display("FAIL %s window cyc=%0d: got (%0d,%0d,k%0d) expected (%0d,%0d,k%0d)",
                             name, cyc, win_x, win_y, kern_sel, wx[0], wy[0], wk[0]);
                end
            end
            checks++;
            if ({busy, done, err} !== {1'b1, exp_done, 1'b0}) begin
                errors++;
                $display("FAIL %s busy_done_err cyc=%0d: got %b%b%b expected 1%b0",
                         name, cyc, busy, done, err, exp_done);
            end

            nd = 1'b0;
            acc_k = -1;
            if (draining && mout == 0) begin
                draining = 1'b0;
                if (wx.size() == 0) nd = 1'b1;
            end
            if (res_valid) mout--;
            if (exp_pr && pix_valid) begin
                void'(lx.pop_front()); void'(ly.pop_front());
                if (lx.size() == 0 && wx.size() == 0) nd = 1'b1;
            end
            if (exp_wv && win_ready) begin
                mout++;
                pend.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                acc_k = wk[0];
                void'(wx.pop_front()); void'(wy.pop_front()); void'(wk.pop_front());
                if (wk.size() == 0 || wk[0] != acc_k) draining = 1'b1;
            end

            if (abort && acc_k == 1) begin
                #2 reset = 1'b1;
                #1;
                checks++;
                if (obs_vec !== RST_EXP) begin
                    errors++;
                    $display("FAIL %s abort_values: got %h expected %h", name, obs_vec, RST_EXP);
                end
                pend.delete();
                start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
                @(negedge clk); reset = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({busy, done} !== 2'b00) begin
                        errors++;
                        $display("FAIL %s after_abort: got busy=%b done=%b expected 0 0", name, busy, done);
                    end
                end
                @(posedge clk); #1;
                aborted = 1'b1;
                break;
            end

            finished = exp_done;
            exp_done = nd;
            @(posedge clk); #1;
            if (finished) break;
        end

        if (!aborted) begin
            checks++;
            if (!finished) begin
                errors++;
                $display("FAIL %s timeout: got no frame end within %0d cycles expected done", name, BUDGET);
            end
            start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, done, phase} !== {1'b0, 1'b0, 3'(IDLE)}) begin
                errors++;
                $display("FAIL %s back_to_idle: got busy=%b done=%b phase=%0d expected 0 0 0",
                         name, busy, done, phase);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_frame();
        run_frame("full_frame", 1'b1, 1'b1, 100, 100, 2, 2, -10, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 1'b1, 1'b1, 100, 100, 6, 6, -10, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_frame("stall", 1'b1, 1'b0, 100, 100, 1, 1, 17, 0, 1'b0);
    endtask

    task automatic test_no_pass();
        run_frame("no_pass", 1'b0, 1'b0, 70, 100, 1, 1, -10, 0, 1'b0);
    endtask

    task automatic test_simultaneous();
        run_frame("simultaneous", 1'b1, 1'b1, 100, 100, 1, 1, -10, 0, 1'b0);
    endtask

    task automatic test_err_idle();
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b expected 1", err);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL err_sticky: got err=%b busy=%b expected 1 0", err, busy);
        end
        run_frame("err_cleared", 1'b0, 1'b1, 90, 90, 1, 3, -10, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame("start_ignored", 1'b1, 1'b1, 80, 80, 1, 4, -10, 30, 1'b0);
    endtask

    task automatic test_abort();
        run_frame("abort", 1'b1, 1'b1, 100, 100, 3, 3, -10, 0, 1'b1);
        run_frame("after_abort", 1'b1, 1'b1, 100, 100, 2, 2, -10, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            run_frame("random", 1'($urandom_range(1)), 1'($urandom_range(1)),
                      int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      1, int'($urandom_range(6, 1)), -10, 10, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_stall();
        test_no_pass();
        test_simultaneous();
        test_err_idle();
        test_start_ignored();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the 3x3 convolution datapath. It loads one grayscale frame into the image buffer in raster order, then scans every interior window through the convolution engine, first with the Gaussian kernel, then with the Sobel kernel (each pass optional). It tracks outstanding engine results and signals frame completion to the downstream gradient/hysteresis stage.

## Interface
Parameters:
- IMG_W, 16, frame width in pixels (≥3)
- IMG_H, 16, frame height in pixels (≥3)
- ADDR_W, 4, width of x/y address (2^ADDR_W ≥ max(IMG_W, IMG_H))
- MAX_OUT, 4, max windows issued to the engine without a returned result

Ports:
- Clock/reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- gauss_en  in  1  run the Gaussian pass; latched on accepted start
- sobel_en  in  1  run the Sobel pass; latched on accepted start
- pix_valid  in  1  input pixel available
- pix_ready  out  1  sequencer accepts a pixel (LOAD only)
- wr_en  out  1  image buffer write strobe
- wr_x, wr_y  out  ADDR_W  buffer write column/row
- win_valid  out  1  window request to the engine
- win_ready  in  1  engine accepts the window
- win_x, win_y  out  ADDR_W  window centre column/row
- kern_sel  out  1  0 = Gaussian, 1 = Sobel
- res_valid  in  1  engine returned one result
- busy  out  1  not in IDLE
- done  out  1  one-cycle frame-complete pulse
- err  out  1  sticky: res_valid received with zero outstanding
- phase  out  3  current state encoding

## Operation
- States: IDLE → LOAD → GAUSS → DRAIN_G → SOBEL → DRAIN_S → DONE → IDLE.
- IDLE: start=1 latches gauss_en/sobel_en, clears counters and err, and moves to LOAD.
- LOAD: pix_ready=1. wr_en = pix_valid & pix_ready (combinational). wr_x/wr_y come from the raster counter: x increments and wraps at IMG_W-1, then y increments. The accept at (IMG_W-1, IMG_H-1) exits to GAUSS if gauss_en, else SOBEL if sobel_en, else DONE.
- GAUSS/SOBEL: the window counter scans x = 1..IMG_W-2 and y = 1..IMG_H-2 in raster order. win_valid=1 while the scan is incomplete and outstanding < MAX_OUT.
  - win_x/win_y stay stable until win_valid & win_ready; the counter then advances.
  - The last accepted window moves the state to the matching DRAIN state.
- DRAIN_G/DRAIN_S: win_valid=0. Exit when outstanding == 0. DRAIN_G exits to SOBEL if sobel_en, else DONE. DRAIN_S exits to DONE.
- kern_sel = 1 in SOBEL/DRAIN_S, else 0.
- Outstanding counter: +1 on window accept, −1 on res_valid, unchanged when both occur in the same cycle. Width is clog2(MAX_OUT+1).
- res_valid with outstanding == 0 (any state) sets err and is otherwise ignored. err clears only on reset or an accepted start.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. gauss_en/sobel_en changes after the latch have no effect.

## Timing
- Reset values: pix_ready=0, wr_en=0, wr_x=wr_y=0, win_valid=0, win_x=win_y=1, kern_sel=0, busy=0, done=0, err=0, phase=IDLE. All counters are 0.
- Reset mid-frame aborts immediately. No done pulse is produced, and outstanding results are discarded.
- Start accepted at cycle t: busy=1 and pix_ready=1 from t+1.
- Window issue: throughput of one window per cycle when win_ready=1 and outstanding < MAX_OUT.
- The cycle after the final load accept is the first GAUSS cycle. win_valid may assert in that same cycle.
- The DRAIN exit decision uses the registered outstanding value. When the last res_valid arrives at cycle t, the next state is entered at t+2.
- done is asserted one cycle after leaving the final DRAIN (or after LOAD when neither pass is enabled). busy drops the cycle after done.

## Structure
- Shared package conv_pkg holds:
  - the phase_t enum (IDLE=0, LOAD=1, GAUSS=2, DRAIN_G=3, SOBEL=4, DRAIN_S=5, DONE=6);
  - the kern_t enum (KERN_GAUSS=0, KERN_SOBEL=1);
  - the default IMG_W/IMG_H constants, which the convolution and gradient modules also use.
- One sub-module, raster_counter: parameters X_MIN, X_MAX, Y_MIN, Y_MAX, W. Ports clk, reset, clr, adv; outputs x, y, last. Instantiate it twice, once for load addressing and once for window scan.

## Test plan
- IMG_W=IMG_H=4, gauss_en=1, sobel_en=1, pix_valid always 1, win_ready=1, results returned 2 cycles after accept:
  - 16 writes at (0,0)…(3,3);
  - 4 Gaussian windows (1,1),(2,1),(1,2),(2,2), then the same 4 with kern_sel=1;
  - one done pulse, err=0.
- Backpressure: MAX_OUT=2, results withheld. win_valid drops after 2 accepts, and resumes one cycle after the next res_valid.
- win_ready low for 5 cycles. win_x/win_y/win_valid stay unchanged, and no window is skipped or duplicated.
- gauss_en=sobel_en=0: 16 pixels loaded, then done, with win_valid never asserted.
- Error and abort cases:
  - res_valid pulsed in IDLE: err=1 until the next accepted start.
  - start pulsed during GAUSS: ignored.
  - reset asserted mid-SOBEL: all outputs return to reset values in the same cycle, and there is no done pulse.
- Simultaneous accept and res_valid at outstanding=MAX_OUT−1: count unchanged, win_valid stays asserted.
